// File: rtl/risc_prog_loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
package risc_prog_loader_pkg;
   localparam logic [7:0] LOADER_MAGIC = 8'hA5;
   localparam int         WORD_W       = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT,
      S_HI,
      S_LO,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_e;
endpackage

// File: rtl/risc_prog_loader_fsm.sv
// Frame parser: state register, checksum and word counters, and the
// registered handshake / core-control outputs.
module risc_loader_fsm
   import risc_prog_loader_pkg::*;
#(
   parameter int          ADDR_W = 8,
   parameter logic [7:0]  MAGIC  = LOADER_MAGIC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   input  logic              rearm,
   output logic              in_ready,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);
   state_e            state_q;
   logic [7:0]        csum_q;
   logic [7:0]        hi_q;
   logic [7:0]        cnt_q;
   logic [ADDR_W-1:0] idx_q;
   logic              in_ready_q;
   logic              cpu_rst_q;
   logic              done_q;
   logic              err_q;
   logic              accept;

   assign accept   = in_valid && in_ready_q;
   assign wr_req   = accept && (state_q == S_LO);
   assign wr_addr  = idx_q;
   assign wr_data  = {hi_q, in_data};
   assign in_ready = in_ready_q;
   assign cpu_rst  = cpu_rst_q;
   assign done     = done_q;
   assign err      = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         csum_q     <= '0;
         hi_q       <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         in_ready_q <= 1'b1;
         cpu_rst_q  <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (accept && in_data == MAGIC) state_q <= S_CNT;
            S_CNT: if (accept) begin
               cnt_q   <= in_data;
               csum_q  <= '0;
               idx_q   <= '0;
               state_q <= (in_data == 8'd0) ? S_CSUM : S_HI;
            end
            S_HI: if (accept) begin
               hi_q    <= in_data;
               csum_q  <= csum_q ^ in_data;
               state_q <= S_LO;
            end
            // cnt_q counts remaining words so N=255 terminates without wrap issues
            S_LO: if (accept) begin
               csum_q  <= csum_q ^ in_data;
               idx_q   <= idx_q + 1'b1;
               cnt_q   <= cnt_q - 8'd1;
               state_q <= (cnt_q == 8'd1) ? S_CSUM : S_HI;
            end
            S_CSUM: if (accept) begin
               in_ready_q <= 1'b0;
               if (in_data == csum_q) begin
                  state_q   <= S_DONE;
                  done_q    <= 1'b1;
                  cpu_rst_q <= 1'b0;
               end else begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
               end
            end
            S_DONE, S_ERR: if (rearm) begin
               state_q    <= S_IDLE;
               in_ready_q <= 1'b1;
               cpu_rst_q  <= 1'b1;
               done_q     <= 1'b0;
               err_q      <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/risc_prog_loader.sv
// Boot loader top: parses the framed byte stream and registers the
// memory write port one cycle after each low-byte handshake.
module risc_prog_loader
   import risc_prog_loader_pkg::*;
#(
   parameter int         ADDR_W = 8,
   parameter logic [7:0] MAGIC  = LOADER_MAGIC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              rearm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [WORD_W-1:0] wr_data;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [WORD_W-1:0] mem_wdata_q;

   risc_loader_fsm #(.ADDR_W(ADDR_W), .MAGIC(MAGIC)) u_fsm (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .rearm    (rearm),
      .in_ready (in_ready),
      .wr_req   (wr_req),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_rst  (cpu_rst),
      .done     (done),
      .err      (err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         mem_we_q <= wr_req;
         if (wr_req) begin
            mem_addr_q  <= wr_addr;
            mem_wdata_q <= wr_data;
         end
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_risc_prog_loader.sv
// Scoreboard bench for risc_prog_loader: frames are built from a byte-level
// model, expected writes queued, and a monitor checks every mem_we.
module tb_risc_prog_loader;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        rearm;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_rst;
   logic        done;
   logic        err;

   int vectors  = 0;
   int miscmp   = 0;
   logic [23:0] exp_q[$];
   logic [7:0]  pl_q[$];

   risc_prog_loader dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rearm     (rearm),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst   (cpu_rst),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst && mem_we) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscmp++;
            $display("FAIL unexpected_write: got addr %h data %h expected none", mem_addr, mem_wdata);
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            chk("write", {mem_addr, mem_wdata}, {8'h0, e});
         end
      end
   end

   // Called at a negedge; leaves the bench at the negedge after the handshake edge.
   task automatic send(input logic [7:0] b, input int stall);
      int t;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         vectors++;
         miscmp++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   function automatic int stall_for(input int mode);
      if (mode == 1) return 1;
      if (mode == 2) return int'($urandom_range(0, 2));
      return 0;
   endfunction

   // Sends MAGIC, N, pl_q, csb; expected writes and outcome come from the model.
   task automatic send_frame(input logic [7:0] csb, input int mode);
      int          n;
      logic [7:0]  cs;
      bit          good;
      n  = pl_q.size() / 2;
      cs = 8'h00;
      foreach (pl_q[i]) cs ^= pl_q[i];
      good = (csb == cs);
      send(8'hA5, stall_for(mode));
      send(8'(n), stall_for(mode));
      for (int i = 0; i < n; i++) begin
         send(pl_q[2*i], stall_for(mode));
         exp_q.push_back({8'(i), pl_q[2*i], pl_q[2*i+1]});
         send(pl_q[2*i+1], stall_for(mode));
      end
      for (int i = 0; i < stall_for(mode); i++) @(negedge clk);
      chk("cpu_rst_before_csum", {31'h0, cpu_rst}, 32'h1);
      send(csb, 0);
      chk("done", {31'h0, done}, {31'h0, good});
      chk("err", {31'h0, err}, {31'h0, !good});
      chk("cpu_rst_after", {31'h0, cpu_rst}, {31'h0, !good});
      chk("in_ready_after", {31'h0, in_ready}, 32'h0);
      repeat (2) @(negedge clk);
      chk("writes_drained", exp_q.size(), 0);
   endtask

   task automatic do_rearm();
      rearm = 1'b1;
      @(negedge clk);
      rearm = 1'b0;
      chk("rearm_done", {31'h0, done}, 32'h0);
      chk("rearm_err", {31'h0, err}, 32'h0);
      chk("rearm_cpu_rst", {31'h0, cpu_rst}, 32'h1);
      chk("rearm_in_ready", {31'h0, in_ready}, 32'h1);
   endtask

   task automatic load_ref();
      pl_q = {8'h12, 8'h34, 8'hAB, 8'hCD};
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; rearm = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
      chk("rst_cpu_rst", {31'h0, cpu_rst}, 32'h1);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
      chk("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
      chk("rst_mem_wdata", {16'h0, mem_wdata}, 32'h0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_state", {29'h0, cpu_rst, in_ready, done}, 32'h6);
      end

      // back-to-back good frame
      load_ref(); send_frame(8'h40, 0); do_rearm();
      // bad checksum, then recovery
      load_ref(); send_frame(8'h41, 0); do_rearm();
      load_ref(); send_frame(8'h40, 0); do_rearm();
      // garbage ahead of an empty program
      send(8'h00, 0); send(8'hFF, 0);
      pl_q = {}; send_frame(8'h00, 0); do_rearm();
      // toggling valid
      load_ref(); send_frame(8'h40, 1); do_rearm();

      // reset mid-frame abandons the partial frame
      send(8'hA5, 0); send(8'h02, 0); send(8'h12, 0);
      rst = 1'b1;
      #1;
      chk("midrst_mem_we", {31'h0, mem_we}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_cpu_rst", {31'h0, cpu_rst}, 32'h1);
      chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
      chk("midrst_done", {31'h0, done}, 32'h0);
      repeat (4) @(negedge clk);
      load_ref(); send_frame(8'h40, 0); do_rearm();

      // randomized frames
      for (int f = 0; f < 25; f++) begin
         int         n;
         int         mode;
         logic [7:0] cs;
         logic [7:0] b;
         n    = int'($urandom_range(0, 8));
         mode = int'($urandom_range(0, 2));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            send(b, stall_for(mode));
         end
         pl_q = {};
         cs = 8'h00;
         for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            pl_q.push_back(b);
            cs ^= b;
         end
         if ($urandom_range(0, 3) == 0) cs ^= 8'($urandom_range(1, 255));
         send_frame(cs, mode);
         do_rearm();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
      $finish;
   end
endmodule
